p_bit: RTL and testbench

Probabilistic bit (p-bit) cell plus its sign-magnitude fixed-point helpers. The block is three modules: `pbit`, `qmult` and `qadd`.
- `pbit` turns a fixed-point synaptic input `z` into a random binary output. The probability of a 1 is (1+tanh(z))/2.
- `qmult` and `qadd` are the combinational multiplier and adder used by the enclosing network to form `z` from weights and neighbouring p-bit states.
- Several `pbit` instances, each with its own seed, are driven by a sequencer that asserts `en` one p-bit at a time.

---
 rtl/p_bit.sv | 173 +++++++++++++++++
 tb/tb_p_bit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/p_bit.sv
// p-bit cell (LFSR-driven stochastic binary neuron) with its sign-magnitude
// fixed-point multiplier and adder, plus a thin top that exposes all three.

module qmult #(
  parameter int Q = 2,
  parameter int N = 7
) (
  input  logic [N-1:0] i_multiplicand,
  input  logic [N-1:0] i_multiplier,
  output logic [N-1:0] o_result,
  output logic         ovr
);
  localparam int M = N - 1;

  logic [2*M-1:0] prod;
  logic [2*M-1:0] shifted;
  logic [M-1:0]   mag;

  always_comb begin
    prod     = {{M{1'b0}}, i_multiplicand[M-1:0]} * {{M{1'b0}}, i_multiplier[M-1:0]};
    shifted  = prod >> Q;
    ovr      = |shifted[2*M-1:M];
    mag      = ovr ? '1 : shifted[M-1:0];
    // Zero magnitude is always reported as +0.
    o_result = {(|mag) & (i_multiplicand[N-1] ^ i_multiplier[N-1]), mag};
  end
endmodule

module qadd #(
  parameter int Q = 2,
  parameter int N = 7
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] c,
  output logic         ovr
);
  localparam int M = N - 1;

  logic [M-1:0] am;
  logic [M-1:0] bm;
  logic [M:0]   sum;
  logic [M-1:0] mag;
  logic         sgn;

  always_comb begin
    am  = a[M-1:0];
    bm  = b[M-1:0];
    sum = {1'b0, am} + {1'b0, bm};
    ovr = 1'b0;
    mag = '0;
    sgn = 1'b0;
    if (a[N-1] == b[N-1]) begin
      ovr = sum[M];
      mag = sum[M] ? '1 : sum[M-1:0];
      sgn = a[N-1];
    end else if (am >= bm) begin
      mag = am - bm;
      sgn = a[N-1];
    end else begin
      mag = bm - am;
      sgn = b[N-1];
    end
    c = {sgn & (|mag), mag};
  end
endmodule

module pbit #(
  parameter logic [31:0] INIT = 32'd1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] z,
  input  logic       en,
  output logic       pbit_val
);
  localparam logic [31:0] SEED = (INIT == 32'd0) ? 32'd1 : INIT;
  localparam logic [31:0] TAPS = 32'h80200003;

  logic [31:0] lfsr;
  logic [15:0] lut_t;
  logic [16:0] neg_t;
  logic [15:0] thresh;

  // round(32768*(1+tanh(m/4))) for magnitude m, saturating at 65535 from m=22.
  function automatic logic [15:0] tanh_lut(input logic [5:0] m);
    case (m)
      6'd0:    tanh_lut = 16'd32768;
      6'd1:    tanh_lut = 16'd40793;
      6'd2:    tanh_lut = 16'd47911;
      6'd3:    tanh_lut = 16'd53581;
      6'd4:    tanh_lut = 16'd57724;
      6'd5:    tanh_lut = 16'd60565;
      6'd6:    tanh_lut = 16'd62428;
      6'd7:    tanh_lut = 16'd63615;
      6'd8:    tanh_lut = 16'd64357;
      6'd9:    tanh_lut = 16'd64816;
      6'd10:   tanh_lut = 16'd65097;
      6'd11:   tanh_lut = 16'd65269;
      6'd12:   tanh_lut = 16'd65374;
      6'd13:   tanh_lut = 16'd65438;
      6'd14:   tanh_lut = 16'd65476;
      6'd15:   tanh_lut = 16'd65500;
      6'd16:   tanh_lut = 16'd65514;
      6'd17:   tanh_lut = 16'd65523;
      6'd18:   tanh_lut = 16'd65528;
      6'd19:   tanh_lut = 16'd65531;
      6'd20:   tanh_lut = 16'd65533;
      6'd21:   tanh_lut = 16'd65534;
      default: tanh_lut = 16'd65535;
    endcase
  endfunction

  always_comb begin
    lut_t  = tanh_lut(z[5:0]);
    neg_t  = 17'h10000 - {1'b0, lut_t};
    thresh = lut_t;
    if (z[6])
      thresh = neg_t[16] ? 16'hFFFF : neg_t[15:0];
  end

  // LFSR free-runs regardless of en; the compare uses the pre-advance value.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lfsr     <= SEED;
      pbit_val <= 1'b0;
    end else begin
      lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : '0);
      if (en)
        pbit_val <= (lfsr[15:0] < thresh);
    end
  end
endmodule

module p_bit #(
  parameter logic [31:0] INIT = 32'd1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] z,
  input  logic       en,
  output logic       pbit_val,
  input  logic [6:0] mult_a,
  input  logic [6:0] mult_b,
  output logic [6:0] mult_result,
  output logic       mult_ovr,
  input  logic [6:0] add_a,
  input  logic [6:0] add_b,
  output logic [6:0] add_c,
  output logic       add_ovr
);
  pbit #(.INIT(INIT)) u_pbit (
    .CLK      (CLK),
    .RST      (RST),
    .z        (z),
    .en       (en),
    .pbit_val (pbit_val)
  );

  qmult #(.Q(2), .N(7)) u_qmult (
    .i_multiplicand (mult_a),
    .i_multiplier   (mult_b),
    .o_result       (mult_result),
    .ovr            (mult_ovr)
  );

  qadd #(.Q(2), .N(7)) u_qadd (
    .a   (add_a),
    .b   (add_b),
    .c   (add_c),
    .ovr (add_ovr)
  );
endmodule

// File: tb/tb_p_bit.sv
// Directed bench for p_bit: fixed-point helper vectors, golden-LFSR bit
// streams for several z values, statistics, hold and asynchronous reset.

module tb_p_bit;
  logic       CLK = 1'b0;
  logic       RST;
  logic [6:0] z;
  logic       en;
  logic       pbit_val;
  logic [6:0] mult_a, mult_b, mult_result;
  logic       mult_ovr;
  logic [6:0] add_a, add_b, add_c;
  logic       add_ovr;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] m_lfsr;
  logic        m_val;

  always #5 CLK = ~CLK;

  p_bit #(.INIT(32'd1)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .z           (z),
    .en          (en),
    .pbit_val    (pbit_val),
    .mult_a      (mult_a),
    .mult_b      (mult_b),
    .mult_result (mult_result),
    .mult_ovr    (mult_ovr),
    .add_a       (add_a),
    .add_b       (add_b),
    .add_c       (add_c),
    .add_ovr     (add_ovr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    lfsr_next = (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
  endfunction

  task automatic mul_vec(input string tag, input logic [6:0] a, input logic [6:0] b,
                         input logic [6:0] exp_r, input logic exp_o);
    mult_a = a;
    mult_b = b;
    #1;
    check({tag, "_res"}, {25'd0, mult_result}, {25'd0, exp_r});
    check({tag, "_ovr"}, {31'd0, mult_ovr}, {31'd0, exp_o});
  endtask

  task automatic add_vec(input string tag, input logic [6:0] a, input logic [6:0] b,
                         input logic [6:0] exp_c, input logic exp_o);
    add_a = a;
    add_b = b;
    #1;
    check({tag, "_sum"}, {25'd0, add_c}, {25'd0, exp_c});
    check({tag, "_ovr"}, {31'd0, add_ovr}, {31'd0, exp_o});
  endtask

  // Called just after a negedge; t is the hand-computed threshold for zv.
  task automatic run_stream(input string tag, input logic [6:0] zv, input logic [15:0] t,
                            input int unsigned n, output int unsigned ones);
    int unsigned bad = 0;
    ones = 0;
    z  = zv;
    en = 1'b1;
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge CLK);
      m_val  = (m_lfsr[15:0] < t);
      m_lfsr = lfsr_next(m_lfsr);
      @(negedge CLK);
      if (pbit_val !== m_val) bad++;
      if (pbit_val === 1'b1) ones++;
    end
    check({tag, "_stream"}, bad, 0);
  endtask

  initial begin
    int unsigned ones;
    int unsigned changes;
    int unsigned waited;
    logic        held;

    RST = 1'b1;
    en  = 1'b0;
    z   = 7'd0;
    mult_a = '0; mult_b = '0; add_a = '0; add_b = '0;

    mul_vec("mul_neg1x1",   7'b1000100, 7'b0000100, 7'b1000100, 1'b0);
    mul_vec("mul_zero_sgn", 7'b0000000, 7'b1000100, 7'b0000000, 1'b0);
    mul_vec("mul_ovr_8x2",  7'b0100000, 7'b0001000, 7'b0111111, 1'b1);
    mul_vec("mul_negneg",   7'b1000110, 7'b1001000, 7'b0001100, 1'b0);
    mul_vec("mul_trunc0",   7'b1000001, 7'b0000011, 7'b0000000, 1'b0);
    mul_vec("mul_maxexact", 7'b1111111, 7'b0000100, 7'b1111111, 1'b0);
    mul_vec("mul_ovr_neg",  7'b1111111, 7'b0111111, 7'b1111111, 1'b1);

    add_vec("add_mixed",    7'b0000100, 7'b1001000, 7'b1000100, 1'b0);
    add_vec("add_cancel",   7'b0000100, 7'b1000100, 7'b0000000, 1'b0);
    add_vec("add_ovr_pos",  7'b0110000, 7'b0110000, 7'b0111111, 1'b1);
    add_vec("add_negneg",   7'b1010000, 7'b1001111, 7'b1011111, 1'b0);
    add_vec("add_max_edge", 7'b0100000, 7'b0011111, 7'b0111111, 1'b0);
    add_vec("add_ovr_neg",  7'b1100000, 7'b1100000, 7'b1111111, 1'b1);
    add_vec("add_bneg_big", 7'b1000011, 7'b0000001, 7'b1000010, 1'b0);
    add_vec("add_negzero",  7'b1000000, 7'b1000000, 7'b0000000, 1'b0);

    @(negedge CLK);
    @(negedge CLK);
    check("reset_val", {31'd0, pbit_val}, 32'd0);
    RST    = 1'b0;
    m_lfsr = 32'd1;
    m_val  = 1'b0;

    run_stream("z_zero", 7'b0000000, 16'd32768, 4096, ones);
    check("z_zero_frac", {31'd0, (ones >= 1843 && ones <= 2252)}, 32'd1);
    run_stream("z_pos1", 7'b0000100, 16'd57724, 4096, ones);
    check("z_pos1_frac", {31'd0, (ones >= 3482 && ones <= 3727)}, 32'd1);
    run_stream("z_negzero", 7'b1000000, 16'd32768, 200, ones);
    run_stream("z_neg1",    7'b1000100, 16'd7812,  200, ones);
    run_stream("z_half",    7'b0000010, 16'd47911, 200, ones);
    run_stream("z_neg1p5",  7'b1000110, 16'd3108,  200, ones);
    run_stream("z_pos3",    7'b0001100, 16'd65374, 200, ones);
    run_stream("z_max",     7'b0011111, 16'd65535, 1000, ones);
    check("z_max_ones", {31'd0, (ones >= 990)}, 32'd1);
    run_stream("z_min",     7'b1100000, 16'd1,     1000, ones);
    check("z_min_ones", {31'd0, (ones <= 10)}, 32'd1);

    // Hold: en low, z wandering; the LFSR must still advance underneath.
    en      = 1'b0;
    held    = pbit_val;
    changes = 0;
    for (int unsigned i = 0; i < 100; i++) begin
      z = 7'($urandom);
      @(posedge CLK);
      m_lfsr = lfsr_next(m_lfsr);
      @(negedge CLK);
      if (pbit_val !== held) changes++;
    end
    check("hold_changes", changes, 0);
    check("hold_val", {31'd0, pbit_val}, {31'd0, m_val});
    run_stream("after_hold", 7'b0000000, 16'd32768, 200, ones);

    // Mid-run asynchronous reset, applied away from any clock edge.
    z = 7'b0011111;
    en = 1'b1;
    waited = 0;
    while (pbit_val !== 1'b1 && waited < 50) begin
      @(negedge CLK);
      waited++;
    end
    check("pre_rst_high", {31'd0, pbit_val}, 32'd1);
    #2;
    RST = 1'b1;
    #1;
    check("async_rst", {31'd0, pbit_val}, 32'd0);
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    check("rst_held", {31'd0, pbit_val}, 32'd0);
    RST    = 1'b0;
    m_lfsr = 32'd1;
    m_val  = 1'b0;
    run_stream("post_rst", 7'b0000000, 16'd32768, 300, ones);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
